// File: rtl/ci74153_pkg.sv
// ci74153_pkg: shared constants and types for the 4-channel TDM reader.
//   NUM_CH    - number of time-multiplexed channels behind the selector
//   SEL_W     - width of the selector address
//   slot_t    - slot / selector address type
//   SLOT_LAST - final slot of a scan before it wraps to 0
package ci74153_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] slot_t;

    localparam slot_t SLOT_LAST = 2'd3;

endpackage

// File: rtl/ci74153_chan_shift.sv
// ci74153_chan_shift: one channel's W-bit deserialiser (MSB arrives first).
//   clk_in  - clock, rising edge
//   clr     - synchronous clear, dominates load_en
//   load_en - shift bit_in into the LSB this edge
//   bit_in  - serial bit from the selector
//   q       - current shift register contents
module ci74153_chan_shift #(
    parameter int W = 8
) (
    input  logic         clk_in,
    input  logic         clr,
    input  logic         load_en,
    input  logic         bit_in,
    output logic [W-1:0] q
);

    always_ff @(posedge clk_in) begin
        if (clr) begin
            q <= '0;
        end else if (load_en) begin
            q <= {q[W-2:0], bit_in};
        end
    end

endmodule

// File: rtl/ci74153_tdm_reader.sv
// ci74153_tdm_reader: receive end of a 4-channel TDM link built on a 4:1
// selector. Scans the selector, deserialises the returned bit into four
// W-bit channel words and offers each completed frame downstream.
//   clk_in       - clock, all state on rising edge
//   rst_in       - synchronous active-high reset
//   en_in        - scan enable; one slot sampled per enabled cycle
//   y_in         - selector output bit
//   sel_out      - selector channel address (registered slot counter)
//   strobe_n_out - selector strobe, active-low, = ~en_in
//   data_out     - frame, channel c at [W*c+W-1 : W*c]
//   valid_out    - data_out holds an unconsumed frame
//   ready_in     - consumer accepts data_out
//   overrun_out  - sticky: a completed frame was dropped
//
// Handshake: a frame moves downstream on any edge where valid_out and
// ready_in are both 1. data_out never changes while valid_out=1 and
// ready_in=0; a frame completing in that state is dropped and flagged on
// overrun_out. A completing frame may replace one being consumed on the
// same edge, so valid_out stays high across back-to-back transfers.
module ci74153_tdm_reader
    import ci74153_pkg::*;
#(
    parameter int W = 8
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            en_in,
    input  logic            y_in,
    output logic [1:0]      sel_out,
    output logic            strobe_n_out,
    output logic [4*W-1:0]  data_out,
    output logic            valid_out,
    input  logic            ready_in,
    output logic            overrun_out
);

    localparam int BIT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);

    slot_t            slot_q;
    logic [BIT_W-1:0] bit_q;
    logic [W-1:0]     shreg [NUM_CH];
    logic             frame_done;
    logic             xfer;
    logic [4*W-1:0]   candidate;

    assign sel_out      = slot_q;
    assign strobe_n_out = ~en_in;
    assign xfer         = valid_out & ready_in;
    assign frame_done   = en_in & (slot_q == SLOT_LAST) & (bit_q == BIT_LAST);

    // Channel 3's final bit is still on y_in at the completing edge, so it
    // is spliced in here rather than read back from its register.
    assign candidate = {shreg[3][W-2:0], y_in, shreg[2], shreg[1], shreg[0]};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        ci74153_chan_shift #(.W(W)) u_shift (
            .clk_in  (clk_in),
            .clr     (rst_in),
            .load_en (en_in && (slot_q == slot_t'(c))),
            .bit_in  (y_in),
            .q       (shreg[c])
        );
    end

    // Slot wraps naturally; bit counter wraps explicitly at W-1.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            slot_q <= '0;
            bit_q  <= '0;
        end else if (en_in) begin
            slot_q <= slot_q + slot_t'(1);
            if (slot_q == SLOT_LAST) begin
                bit_q <= (bit_q == BIT_LAST) ? '0 : bit_q + BIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            data_out    <= '0;
            valid_out   <= 1'b0;
            overrun_out <= 1'b0;
        end else if (frame_done) begin
            if (!valid_out || ready_in) begin
                data_out  <= candidate;
                valid_out <= 1'b1;
            end else begin
                overrun_out <= 1'b1;
            end
        end else if (xfer) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ci74153_tdm_reader.sv
// Directed bench for ci74153_tdm_reader (W=8). The bench plays the remote
// mux: sample k of a frame carries bit (7 - k/4) of channel (k%4)'s word.
module tb_ci74153_tdm_reader;

    localparam int W = 8;

    logic           clk_in;
    logic           rst_in;
    logic           en_in;
    logic           y_in;
    logic [1:0]     sel_out;
    logic           strobe_n_out;
    logic [4*W-1:0] data_out;
    logic           valid_out;
    logic           ready_in;
    logic           overrun_out;

    int n_cmp;
    int n_err;

    ci74153_tdm_reader #(.W(W)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .en_in        (en_in),
        .y_in         (y_in),
        .sel_out      (sel_out),
        .strobe_n_out (strobe_n_out),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .overrun_out  (overrun_out)
    );

    // clock / reset
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic step;
        @(posedge clk_in);
        #1;
    endtask

    // driver: n samples of a frame, optional idle cycle after each sample,
    // optional ready_in=1 presented with the final sample.
    task automatic send_frame(input logic [7:0] w0, input logic [7:0] w1,
                              input logic [7:0] w2, input logic [7:0] w3,
                              input bit gaps, input bit ready_last, input int n);
        logic [7:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int k = 0; k < n; k++) begin
            en_in = 1'b1;
            y_in  = w[k % 4][7 - k / 4];
            if (ready_last && k == 31) ready_in = 1'b1;
            #1;
            n_cmp++;
            if (sel_out !== 2'(k % 4)) begin
                n_err++;
                $display("FAIL sel k=%0d: got %0d want %0d", k, sel_out, k % 4);
            end
            n_cmp++;
            if (strobe_n_out !== 1'b0) begin
                n_err++;
                $display("FAIL strobe_on k=%0d: got %b want 0", k, strobe_n_out);
            end
            step();
            if (gaps && k < n - 1) begin
                en_in = 1'b0;
                y_in  = ~y_in;
                #1;
                n_cmp++;
                if (strobe_n_out !== 1'b1 || sel_out !== 2'((k + 1) % 4)) begin
                    n_err++;
                    $display("FAIL gap_hold k=%0d: strobe_n=%b sel=%0d want 1/%0d",
                             k, strobe_n_out, sel_out, (k + 1) % 4);
                end
                step();
            end
        end
        en_in = 1'b0;
    endtask

    task automatic check_frame(input string name, input logic v,
                               input logic [31:0] d, input logic ov);
        n_cmp++;
        if (valid_out !== v || data_out !== d || overrun_out !== ov) begin
            n_err++;
            $display("FAIL %s: valid=%b data=%h overrun=%b want %b/%h/%b",
                     name, valid_out, data_out, overrun_out, v, d, ov);
        end
    endtask

    task automatic test_reset;
        rst_in = 1'b1;
        en_in  = 1'b1;
        y_in   = 1'b1;
        step();
        n_cmp++;
        if (sel_out !== 2'd0 || data_out !== '0 || valid_out !== 1'b0 ||
            overrun_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset: sel=%0d data=%h valid=%b overrun=%b want all 0",
                     sel_out, data_out, valid_out, overrun_out);
        end
        rst_in = 1'b0;
        en_in  = 1'b0;
    endtask

    task automatic test_basic;
        ready_in = 1'b1;
        send_frame(8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b0, 1'b0, 32);
        check_frame("basic_frame", 1'b1, 32'h00FF3CA5, 1'b0);
        step();
        check_frame("basic_drop", 1'b0, 32'h00FF3CA5, 1'b0);
    endtask

    task automatic test_enable_gaps;
        ready_in = 1'b1;
        send_frame(8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b1, 1'b0, 32);
        check_frame("gaps_frame", 1'b1, 32'h00FF3CA5, 1'b0);
        step();
        check_frame("gaps_drop", 1'b0, 32'h00FF3CA5, 1'b0);
    endtask

    task automatic test_overrun;
        ready_in = 1'b0;
        send_frame(8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b0, 1'b0, 32);
        check_frame("ovr_first", 1'b1, 32'h00FF3CA5, 1'b0);
        send_frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0, 32);
        check_frame("ovr_second", 1'b1, 32'h00FF3CA5, 1'b1);
        step();
        check_frame("ovr_sticky", 1'b1, 32'h00FF3CA5, 1'b1);
    endtask

    task automatic test_back_to_back;
        ready_in = 1'b0;
        send_frame(8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b0, 1'b0, 32);
        check_frame("b2b_first", 1'b1, 32'h00FF3CA5, 1'b0);
        send_frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b1, 32);
        check_frame("b2b_second", 1'b1, 32'h44332211, 1'b0);
        step();
        check_frame("b2b_drop", 1'b0, 32'h44332211, 1'b0);
    endtask

    task automatic test_abort;
        ready_in = 1'b1;
        send_frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0, 13);
        n_cmp++;
        if (sel_out !== 2'd1) begin
            n_err++;
            $display("FAIL abort_sel: got %0d want 1", sel_out);
        end
        test_reset();
        send_frame(8'h5A, 8'hC3, 8'h0F, 8'hF0, 1'b0, 1'b0, 32);
        check_frame("abort_frame", 1'b1, 32'hF00FC35A, 1'b0);
        step();
    endtask

    task automatic test_alternating;
        ready_in = 1'b1;
        send_frame(8'h55, 8'hAA, 8'h55, 8'hAA, 1'b0, 1'b0, 32);
        check_frame("alt_frame", 1'b1, 32'hAA55AA55, 1'b0);
        step();
        check_frame("alt_drop", 1'b0, 32'hAA55AA55, 1'b0);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_in   = 1'b1;
        en_in    = 1'b0;
        y_in     = 1'b0;
        ready_in = 1'b0;
        test_reset();
        test_basic();
        test_enable_gaps();
        test_overrun();
        test_reset();
        test_back_to_back();
        test_abort();
        test_alternating();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ci74153_tdm_reader.md
Name: ci74153_tdm_reader

Overview:
Receive end of a 4-channel time-division link built on a 4:1 selector.
- Drives the selector's 2-bit select and active-low strobe.
- Samples the single returned bit and deserialises it into four W-bit channel words.
- Presents each completed frame on a valid/ready output handshake.
- Sits between the remote 4:1 mux and downstream word consumers.

Parameters:
W, 8, bits per channel word; legal 2..32; sent MSB first.

Ports:
clk_in  input  1  system clock; all state updates on the rising edge.
rst_in  input  1  reset, synchronous, active-high.
en_in  input  1  scan enable; 1 = sample one slot this cycle.
y_in  input  1  selector output; valid in any cycle with strobe_n_out=0.
sel_out  output  2  selector channel address for the current slot.
strobe_n_out  output  1  selector strobe, active-low; equal to ~en_in (combinational).
data_out  output  4*W  frame: channel c at bits [W*c+W-1 : W*c].
valid_out  output  1  data_out holds an unconsumed frame.
ready_in  input  1  consumer accepts data_out when valid_out=1.
overrun_out  output  1  sticky; a completed frame was dropped.

Behaviour:
- Reset state (applies at any edge with rst_in=1):
  - sel_out=0, data_out=0, valid_out=0, overrun_out=0.
  - slot counter=0, bit counter=0, all shift registers=0.
  - Any partial frame is discarded; reset dominates every other event.
- Sampling:
  - A sampling edge is any rising edge with en_in=1 and rst_in=0.
  - At that edge: shreg[sel_out] <= {shreg[sel_out][W-2:0], y_in}.
  - sel_out is the registered slot counter; it advances 0,1,2,3,0 on each sampling edge.
  - When the slot wraps 3->0, the bit counter increments.
- Enable:
  - en_in=0: no sample; sel_out, the counters and the shift registers hold.
  - strobe_n_out=1 for that cycle.
- Frame complete:
  - Occurs at the sampling edge with slot=3 and bit counter=W-1, i.e. the 4*W-th sample.
  - At that edge the candidate frame is the four shift registers, with channel 3 taking {shreg[3][W-2:0], y_in}.
  - Bit counter returns to 0 and slot to 0, so the next frame starts immediately.
  - Capture never stalls.
- Output handshake (evaluated each edge; "xfer" = valid_out & ready_in):
  - Frame complete and (valid_out=0 or xfer): data_out <= candidate; valid_out <= 1.
  - Frame complete, valid_out=1, ready_in=0: candidate dropped; data_out is unchanged; overrun_out <= 1.
  - xfer with no frame complete: valid_out <= 0.
- Latency:
  - valid_out rises in the cycle after the final sampling edge.
  - data_out is stable while valid_out=1 and ready_in=0.
- overrun_out clears only on rst_in.
- Widths:
  - Slot counter is 2 bits and wraps naturally.
  - Bit counter is $clog2(W) bits and wraps explicitly at W-1.

Decomposition:
- Package ci74153_pkg:
  - NUM_CH=4, SEL_W=2.
  - typedef slot_t (logic [1:0]).
  - Constant SLOT_LAST=2'd3.
- Sub-module ci74153_chan_shift: one W-bit shift register per channel, with load enable and synchronous clear. Instantiated 4 times with enable (sel_out==c) & en_in.
- Counters and the handshake stay in the top module.

Test Plan (W=8):
1. Bench models the mux with words A5,3C,FF,00 on ch0..3; reset, then en_in=1 for 32 cycles, ready_in=1.
   -> sel_out cycles 0,1,2,3.
   -> valid_out=1 in cycle 33 with data_out=0x00FF3CA5; valid_out drops the next cycle.
2. Same words, en_in toggled 1,0,1,0 across the frame.
   -> sel_out and the counters hold whenever en_in=0; strobe_n_out=1 in those cycles.
   -> Identical data_out after 32 sampling edges.
3. ready_in=0; two back-to-back frames, second frame words 11,22,33,44.
   -> First frame held: data_out=0x00FF3CA5.
   -> overrun_out=1 after the 64th sampling edge; second frame dropped.
4. ready_in rises exactly at the edge where the second frame completes.
   -> valid_out stays 1; data_out=0x44332211; overrun_out stays 0.
5. rst_in=1 for 1 cycle after 13 samples, then a full frame of words 5A,C3,0F,F0.
   -> All outputs 0 during reset; sel_out restarts at 0.
   -> data_out=0xF00FC35A with no residue from the aborted frame.
6. Alternating-bit words 55,AA,55,AA checked against the bench mux model.
   -> Confirms MSB-first ordering and channel placement: data_out=0xAA55AA55.
